sync_delay_measure: RTL and testbench

SYNC_DELAY_MEASURE -- requirements
Module: sync_delay_measure

---
 rtl/sync_delay_measure.sv | 134 +++++++++++++
 tb/tb_sync_delay_measure.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_delay_measure.sv
// sync_delay_measure: launches a one-cycle sync pulse and measures, in clk
// cycles, how long it takes for the echo to come back on sync_in. Aborts with
// a timeout strobe after TIMEOUT_CYCLES cycles without an echo.
// Optional feature: define SYNC_DELAY_MEASURE_MINMAX_EN to add running
// min_delay/max_delay tracking with a minmax_clr restart input.
module sync_delay_measure #(
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sync_in,
  output logic                   sync_out,
  output logic [COUNT_WIDTH-1:0] delay,
  output logic                   dvalid,
  output logic                   busy,
  output logic                   timeout
`ifdef SYNC_DELAY_MEASURE_MINMAX_EN
  ,
  input  logic                   minmax_clr,
  output logic [COUNT_WIDTH-1:0] min_delay,
  output logic [COUNT_WIDTH-1:0] max_delay
`endif
);

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_d;
  logic                   sync_out_q;
  logic [COUNT_WIDTH-1:0] delay_q;
  logic                   dvalid_q;
  logic                   busy_q;
  logic                   timeout_q;

  // Counter increment; bounded by TIMEOUT_VAL so it never wraps.
  always_comb begin
    cnt_d = cnt_q + COUNT_WIDTH'(1);
  end

  // Measurement FSM with registered strobes. The counter holds 0 during LAUNCH
  // and k in the k-th WAIT cycle, so it equals the echo delay directly and an
  // echo seen in LAUNCH yields 0. Echo is tested before timeout so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sync_out_q <= 1'b0;
      delay_q    <= '0;
      dvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      sync_out_q <= 1'b0;
      dvalid_q   <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LAUNCH;
            cnt_q      <= '0;
            sync_out_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LAUNCH, WAIT: begin
          if (sync_in) begin
            delay_q  <= cnt_q;
            dvalid_q <= 1'b1;
            state_q  <= DONE;
          end else if (cnt_q == TIMEOUT_VAL) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q   <= cnt_d;
            state_q <= WAIT;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sync_out = sync_out_q;
  assign delay    = delay_q;
  assign dvalid   = dvalid_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

`ifdef SYNC_DELAY_MEASURE_MINMAX_EN
  logic [COUNT_WIDTH-1:0] min_q;
  logic [COUNT_WIDTH-1:0] max_q;
  logic                   fresh_q;

  // Running extremes over dvalid results; after reset or minmax_clr the next
  // result loads both (a clear coinciding with dvalid loads from that result).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q   <= '0;
      max_q   <= '0;
      fresh_q <= 1'b1;
    end else if (dvalid_q) begin
      if (fresh_q || minmax_clr) begin
        min_q <= delay_q;
        max_q <= delay_q;
      end else begin
        if (delay_q < min_q) min_q <= delay_q;
        if (delay_q > max_q) max_q <= delay_q;
      end
      fresh_q <= 1'b0;
    end else if (minmax_clr) begin
      fresh_q <= 1'b1;
    end
  end

  assign min_delay = min_q;
  assign max_delay = max_q;
`endif

endmodule

// File: tb/tb_sync_delay_measure.sv
// Directed testbench for sync_delay_measure with a loopback echo model.
module tb_sync_delay_measure;

  localparam int unsigned CW = 16;
`ifdef SYNC_DELAY_MEASURE_MINMAX_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sync_in;
  logic          sync_out;
  logic [CW-1:0] delay;
  logic          dvalid;
  logic          busy;
  logic          timeout;
`ifdef SYNC_DELAY_MEASURE_MINMAX_EN
  logic          minmax_clr = 1'b0;
  logic [CW-1:0] min_delay;
  logic [CW-1:0] max_delay;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  logic [63:0] hist = '0;
  int          echo_d = -1;   // -1: no echo, 0: combinational loop, >0: delayed
  logic        manual = 1'b0;

  // Monitor counters (cumulative) and last-seen cycles
  int dv_cnt = 0, to_cnt = 0, so_cnt = 0;
  int dv_cyc = 0, to_cyc = 0, so_cyc = 0, so_prev = 0;
  int dv_val = 0;
  int b_dv, b_to, b_so, launch;

  sync_delay_measure #(
    .COUNT_WIDTH   (CW),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sync_in   (sync_in),
    .sync_out  (sync_out),
    .delay     (delay),
    .dvalid    (dvalid),
    .busy      (busy),
    .timeout   (timeout)
`ifdef SYNC_DELAY_MEASURE_MINMAX_EN
    ,
    .minmax_clr(minmax_clr),
    .min_delay (min_delay),
    .max_delay (max_delay)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hist <= {hist[62:0], sync_out};
  end

  always_comb begin
    sync_in = manual;
    if (echo_d == 0) sync_in = manual | sync_out;
    else if (echo_d > 0) sync_in = manual | hist[echo_d-1];
  end

  always @(negedge clk) begin
    if (sync_out) begin so_cnt++; so_prev = so_cyc; so_cyc = cyc; end
    if (dvalid)   begin dv_cnt++; dv_cyc = cyc; dv_val = int'(delay); end
    if (timeout)  begin to_cnt++; to_cyc = cyc; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_dv = dv_cnt;
    b_to = to_cnt;
    b_so = so_cnt;
  endtask

  // Launch one measurement with the given echo mode and let it settle.
  task automatic run_meas(input int d);
    mark();
    echo_d = d;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    launch = cyc;
    repeat (TO + 5) tick();
    echo_d = -1;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_sync_out", sync_out, 0);
    check("rst_busy", busy, 0);
    check("rst_delay", delay, 0);
    check("rst_dvalid", dvalid, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    // Start at cycle 10, 5-cycle loopback
    for (int i = 0; i < 20 && cyc < 10; i++) tick();
    check("c10_reach", cyc, 10);
    run_meas(5);
    check("d5_launch_cyc", so_cyc, 11);
    check("d5_sync_pulses", so_cnt - b_so, 1);
    check("d5_dvalid_cnt", dv_cnt - b_dv, 1);
    check("d5_dvalid_cyc", dv_cyc, 17);
    check("d5_dvalid_val", dv_val, 5);
    check("d5_delay_hold", delay, 5);
    check("d5_no_timeout", to_cnt - b_to, 0);
    check("d5_busy_after", busy, 0);

    // No echo: timeout, delay unchanged
    run_meas(-1);
    check("to_cnt", to_cnt - b_to, 1);
    check("to_cyc", to_cyc, launch + TO + 1);
    check("to_no_dvalid", dv_cnt - b_dv, 0);
    check("to_delay_kept", delay, 5);
    check("to_busy_after", busy, 0);

    // Echo one cycle too late is still a timeout
    run_meas(TO + 1);
    check("late_to_cnt", to_cnt - b_to, 1);
    check("late_no_dvalid", dv_cnt - b_dv, 0);

    // Combinational loopback: delay 0
    run_meas(0);
    check("d0_dvalid_cnt", dv_cnt - b_dv, 1);
    check("d0_dvalid_val", dv_val, 0);
    check("d0_dvalid_cyc", dv_cyc, launch + 1);
    check("d0_delay", delay, 0);

    // Echo exactly when the counter reaches TIMEOUT_CYCLES: echo wins
    run_meas(TO);
    check("dto_dvalid_cnt", dv_cnt - b_dv, 1);
    check("dto_dvalid_val", dv_val, TO);
    check("dto_no_timeout", to_cnt - b_to, 0);

    // Stray echo in IDLE does nothing
    mark();
    manual = 1'b1;
    tick();
    manual = 1'b0;
    repeat (3) tick();
    check("stray_delay", delay, TO);
    check("stray_no_dvalid", dv_cnt - b_dv, 0);
    check("stray_busy", busy, 0);

    // Back-to-back with start held high: period delay+3
    mark();
    echo_d = 2;
    start  = 1'b1;
    for (int i = 0; i < 40 && (so_cnt - b_so) < 2; i++) tick();
    start = 1'b0;
    repeat (TO + 5) tick();
    echo_d = -1;
    check("b2b_period", so_cyc - so_prev, 5);
    check("b2b_dvalid_cnt", dv_cnt - b_dv, 2);
    check("b2b_delay", delay, 2);

    // Reset while in WAIT
    mark();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_delay", delay, 0);
    check("mid_rst_sync_out", sync_out, 0);
    check("mid_rst_dvalid", dvalid, 0);
    check("mid_rst_timeout", timeout, 0);
`ifdef SYNC_DELAY_MEASURE_MINMAX_EN
    check("mid_rst_min", min_delay, 0);
    check("mid_rst_max", max_delay, 0);
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (TO + 3) tick();
    check("mid_no_dvalid", dv_cnt - b_dv, 0);
    check("mid_no_timeout", to_cnt - b_to, 0);
    run_meas(3);
    check("mid_d3_dvalid_cnt", dv_cnt - b_dv, 1);
    check("mid_d3_delay", delay, 3);

`ifdef SYNC_DELAY_MEASURE_MINMAX_EN
    minmax_clr = 1'b1;
    tick();
    minmax_clr = 1'b0;
    run_meas(7);
    check("mm_first_min", min_delay, 7);
    check("mm_first_max", max_delay, 7);
    run_meas(2);
    run_meas(9);
    check("mm_min", min_delay, 2);
    check("mm_max", max_delay, 9);
    minmax_clr = 1'b1;
    tick();
    minmax_clr = 1'b0;
    run_meas(4);
    check("mm_clr_min", min_delay, 4);
    check("mm_clr_max", max_delay, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
